// File: rtl/gpu_pkg.sv
// Shared encodings and widths for the core pipeline: scheduler states, fetcher states,
// and the program-memory geometry used by fetcher, pc_nzp and the decoder.
package gpu_pkg;

    localparam int PROGRAM_MEM_ADDR_BITS = 8;
    localparam int PROGRAM_MEM_DATA_BITS = 16;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [1:0] {
        FS_IDLE     = 2'b00,
        FS_FETCHING = 2'b01,
        FS_FETCHED  = 2'b10
    } fetcher_state_t;

endpackage

// File: rtl/fetch_line_buffer.sv
// One-entry instruction line buffer {valid, tag, data}. Cleared only by reset, since
// program memory is read-only for the life of a kernel.
module fetch_line_buffer
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS = PROGRAM_MEM_ADDR_BITS,
    parameter int DATA_BITS = PROGRAM_MEM_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_tag,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic [ADDR_BITS-1:0] lookup_addr,
    output logic                 hit,
    output logic [DATA_BITS-1:0] rd_data
);

    logic                 valid;
    logic [ADDR_BITS-1:0] tag;
    logic [DATA_BITS-1:0] data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (wr_en) begin
            valid <= 1'b1;
            tag   <= wr_tag;
            data  <= wr_data;
        end
    end

    assign hit     = valid && (tag == lookup_addr);
    assign rd_data = data;

endmodule

// File: rtl/fetcher.sv
// Instruction fetch stage: owns the architectural PC, fetches the word at the PC over a
// valid/ready handshake and skips the round-trip when the line buffer already holds it.
module fetcher
    import gpu_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = gpu_pkg::PROGRAM_MEM_ADDR_BITS,
    parameter int PROGRAM_MEM_DATA_BITS = gpu_pkg::PROGRAM_MEM_DATA_BITS
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             enable,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] next_pc,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [1:0]                       fetcher_state,
    output logic                             fetch_hit
);

    fetcher_state_t state, state_nxt;

    logic [PROGRAM_MEM_ADDR_BITS-1:0] pc_q;
    logic                             valid_q, valid_nxt;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_q, addr_nxt;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q, instr_nxt;
    logic                             hit_q, hit_nxt;
    logic                             buf_wr;
    logic                             buf_hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] buf_data;

    fetch_line_buffer #(
        .ADDR_BITS(PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS(PROGRAM_MEM_DATA_BITS)
    ) u_line_buffer (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (buf_wr),
        .wr_tag     (pc_q),
        .wr_data    (mem_read_data),
        .lookup_addr(pc_q),
        .hit        (buf_hit),
        .rd_data    (buf_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= '0;
        end else if (enable && core_state == CORE_UPDATE) begin
            pc_q <= next_pc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= FS_IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            instr_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            valid_q <= valid_nxt;
            addr_q  <= addr_nxt;
            instr_q <= instr_nxt;
            hit_q   <= hit_nxt;
        end
    end

    // hit_nxt defaults low every cycle so fetch_hit is a true single-cycle pulse.
    always_comb begin
        state_nxt = state;
        valid_nxt = valid_q;
        addr_nxt  = addr_q;
        instr_nxt = instr_q;
        hit_nxt   = 1'b0;
        buf_wr    = 1'b0;
        if (enable) begin
            case (state)
                FS_IDLE: begin
                    if (core_state == CORE_FETCH) begin
                        if (buf_hit) begin
                            instr_nxt = buf_data;
                            hit_nxt   = 1'b1;
                            state_nxt = FS_FETCHED;
                        end else begin
                            valid_nxt = 1'b1;
                            addr_nxt  = pc_q;
                            state_nxt = FS_FETCHING;
                        end
                    end
                end
                FS_FETCHING: begin
                    if (mem_read_ready) begin
                        instr_nxt = mem_read_data;
                        buf_wr    = 1'b1;
                        valid_nxt = 1'b0;
                        state_nxt = FS_FETCHED;
                    end
                end
                FS_FETCHED: begin
                    if (core_state == CORE_DECODE) begin
                        state_nxt = FS_IDLE;
                    end
                end
                default: begin
                    state_nxt = FS_IDLE;
                    valid_nxt = 1'b0;
                end
            endcase
        end
    end

    assign current_pc       = pc_q;
    assign mem_read_valid   = valid_q;
    assign mem_read_address = addr_q;
    assign instruction      = instr_q;
    assign fetcher_state    = state;
    assign fetch_hit        = hit_q;

endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher: miss/hit paths, PC update, enable freeze, async reset
// and stray memory-ready pulses, with hand-computed expectations.
module tb_fetcher;

    localparam logic [2:0] CS_IDLE   = 3'b000;
    localparam logic [2:0] CS_FETCH  = 3'b001;
    localparam logic [2:0] CS_DECODE = 3'b010;
    localparam logic [2:0] CS_UPDATE = 3'b110;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [2:0]  core_state;
    logic [7:0]  next_pc;
    logic [7:0]  current_pc;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [15:0] instruction;
    logic [1:0]  fetcher_state;
    logic        fetch_hit;

    int n_checks = 0;
    int n_pass   = 0;

    fetcher dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .core_state      (core_state),
        .next_pc         (next_pc),
        .current_pc      (current_pc),
        .mem_read_valid  (mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready  (mem_read_ready),
        .mem_read_data   (mem_read_data),
        .instruction     (instruction),
        .fetcher_state   (fetcher_state),
        .fetch_hit       (fetch_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_val);
        n_checks++;
        if (obs === exp_val) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_val);
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic decode_to_idle(input string tag);
        core_state = CS_DECODE;
        step();
        check({tag, "_idle"}, 16'(fetcher_state), 16'h0);
        core_state = CS_IDLE;
    endtask

    initial begin
        reset_n        = 1'b0;
        enable         = 1'b1;
        core_state     = CS_IDLE;
        next_pc        = 8'h00;
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0000;
        step(3);
        check("rst_pc",    16'(current_pc),       16'h0);
        check("rst_state", 16'(fetcher_state),    16'h0);
        check("rst_valid", 16'(mem_read_valid),   16'h0);
        check("rst_addr",  16'(mem_read_address), 16'h0);
        check("rst_instr", instruction,           16'h0);
        check("rst_hit",   16'(fetch_hit),        16'h0);
        reset_n = 1'b1;
        step();

        // 1: cold miss at PC 0, memory answers three cycles after the request
        core_state = CS_FETCH;
        step();
        check("t1_state", 16'(fetcher_state),    16'h1);
        check("t1_valid", 16'(mem_read_valid),   16'h1);
        check("t1_addr",  16'(mem_read_address), 16'h00);
        step(2);
        check("t1_wait_valid", 16'(mem_read_valid), 16'h1);
        check("t1_wait_state", 16'(fetcher_state),  16'h1);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h1234;
        step();
        mem_read_ready = 1'b0;
        check("t1_state_done", 16'(fetcher_state),  16'h2);
        check("t1_instr",      instruction,         16'h1234);
        check("t1_hit",        16'(fetch_hit),      16'h0);
        check("t1_valid_drop", 16'(mem_read_valid), 16'h0);
        step();
        check("t1_hold", 16'(fetcher_state), 16'h2);
        decode_to_idle("t1");

        // 2: same PC again is served from the buffer
        core_state = CS_FETCH;
        step();
        check("t2_state", 16'(fetcher_state),  16'h2);
        check("t2_instr", instruction,         16'h1234);
        check("t2_hit",   16'(fetch_hit),      16'h1);
        check("t2_valid", 16'(mem_read_valid), 16'h0);
        decode_to_idle("t2");
        check("t2_hit_pulse", 16'(fetch_hit), 16'h0);

        // 3: PC update then miss at 0x07
        core_state = CS_UPDATE;
        next_pc    = 8'h07;
        step();
        check("t3_pc",         16'(current_pc),    16'h07);
        check("t3_state_idle", 16'(fetcher_state), 16'h0);
        core_state = CS_FETCH;
        step();
        check("t3_state", 16'(fetcher_state),    16'h1);
        check("t3_valid", 16'(mem_read_valid),   16'h1);
        check("t3_addr",  16'(mem_read_address), 16'h07);
        check("t3_hit",   16'(fetch_hit),        16'h0);

        // 4: enable low freezes the fetch while ready is held
        enable         = 1'b0;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hBEEF;
        step(4);
        check("t4_state", 16'(fetcher_state),    16'h1);
        check("t4_valid", 16'(mem_read_valid),   16'h1);
        check("t4_addr",  16'(mem_read_address), 16'h07);
        check("t4_instr", instruction,           16'h1234);
        enable = 1'b1;
        step();
        mem_read_ready = 1'b0;
        check("t4_state_done", 16'(fetcher_state),  16'h2);
        check("t4_instr_done", instruction,         16'hBEEF);
        check("t4_valid_drop", 16'(mem_read_valid), 16'h0);
        decode_to_idle("t4");
        core_state = CS_FETCH;
        step();
        check("t4_refetch_hit",   16'(fetch_hit),   16'h1);
        check("t4_refetch_instr", instruction,      16'hBEEF);
        decode_to_idle("t4r");

        // 5: fill buffer at PC 0, then reset mid-fetch must invalidate it
        core_state = CS_UPDATE;
        next_pc    = 8'h00;
        step();
        core_state = CS_FETCH;
        step();
        check("t5_miss0", 16'(fetcher_state), 16'h1);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h5A5A;
        step();
        mem_read_ready = 1'b0;
        check("t5_instr0", instruction, 16'h5A5A);
        decode_to_idle("t5a");
        core_state = CS_FETCH;
        step();
        check("t5_hit0", 16'(fetch_hit), 16'h1);
        decode_to_idle("t5b");
        core_state = CS_UPDATE;
        next_pc    = 8'hFF;
        step();
        check("t5_pc_ff", 16'(current_pc), 16'hFF);
        core_state = CS_FETCH;
        step();
        check("t5_addr_ff", 16'(mem_read_address), 16'hFF);
        #1 reset_n = 1'b0;
        #1;
        check("t5_rst_valid", 16'(mem_read_valid), 16'h0);
        check("t5_rst_state", 16'(fetcher_state),  16'h0);
        check("t5_rst_pc",    16'(current_pc),     16'h0);
        check("t5_rst_instr", instruction,         16'h0);
        step();
        reset_n = 1'b1;
        step();
        check("t5_post_miss_state", 16'(fetcher_state),    16'h1);
        check("t5_post_miss_hit",   16'(fetch_hit),        16'h0);
        check("t5_post_miss_addr",  16'(mem_read_address), 16'h00);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h0F0F;
        step();
        mem_read_ready = 1'b0;
        check("t5_post_instr", instruction, 16'h0F0F);

        // 6: stray ready pulses in FETCHED and IDLE are ignored
        core_state     = CS_IDLE;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hDEAD;
        step();
        mem_read_ready = 1'b0;
        check("t6_fetched_state", 16'(fetcher_state), 16'h2);
        check("t6_fetched_instr", instruction,        16'h0F0F);
        decode_to_idle("t6");
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hCAFE;
        step(2);
        mem_read_ready = 1'b0;
        check("t6_idle_state", 16'(fetcher_state),  16'h0);
        check("t6_idle_instr", instruction,         16'h0F0F);
        check("t6_idle_valid", 16'(mem_read_valid), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
